// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART sender between NUM_REQ requesters.
// A granted byte and its frame settings are latched onto the sender inputs.
// The arbiter then strobes tx_valid, waits for tx_done/tx_err or a timeout,
// and returns a one-cycle done or error pulse to the requester that owned it.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned BITCNT_WIDTH = 4,
    parameter int unsigned TIMEOUT_CYC  = 65535
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              arb_en,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*8-1:0]              req_data,
    input  logic [NUM_REQ*BITCNT_WIDTH-1:0]   req_len,
    input  logic [NUM_REQ-1:0]                req_parity_en,
    input  logic [NUM_REQ-1:0]                req_parity_type,
    input  logic [NUM_REQ-1:0]                req_stop2,
    output logic [NUM_REQ-1:0]                resp_done,
    output logic [NUM_REQ-1:0]                resp_err,
    output logic                              timeout,
    output logic [7:0]                        tx_data,
    output logic [BITCNT_WIDTH-1:0]           trans_len,
    output logic                              parity_type,
    output logic                              parity_en,
    output logic                              stop2,
    output logic                              tx_valid,
    output logic                              en,
    input  logic                              tx_done,
    input  logic                              tx_err
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {StIdle, StIssue, StBusy, StResp} state_e;

    state_e                   state_q;
    logic [IdxW-1:0]          rr_ptr_q;
    logic [IdxW-1:0]          owner_q;
    logic [CntW-1:0]          cnt_q;
    logic                     en_q;
    logic                     tx_valid_q;
    logic [NUM_REQ-1:0]       resp_done_q;
    logic [NUM_REQ-1:0]       resp_err_q;
    logic                     timeout_q;
    logic [7:0]               tx_data_q;
    logic [BITCNT_WIDTH-1:0]  trans_len_q;
    logic                     parity_type_q;
    logic                     parity_en_q;
    logic                     stop2_q;

    logic                     grant_found;
    logic [IdxW-1:0]          grant_idx;
    int unsigned              cand;
    logic [IdxW-1:0]          cand_idx;
    logic [7:0]               sel_data;
    logic [BITCNT_WIDTH-1:0]  sel_len;
    logic                     sel_parity_en;
    logic                     sel_parity_type;
    logic                     sel_stop2;
    logic                     sel_len_bad;
    logic                     accept;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand     = (32'(rr_ptr_q) + i) % NUM_REQ;
            cand_idx = IdxW'(cand);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Mux out the winner's byte and frame settings.
    always_comb begin
        sel_data        = '0;
        sel_len         = '0;
        sel_parity_en   = 1'b0;
        sel_parity_type = 1'b0;
        sel_stop2       = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IdxW'(i)) begin
                sel_data        = req_data[i*8 +: 8];
                sel_len         = req_len[i*BITCNT_WIDTH +: BITCNT_WIDTH];
                sel_parity_en   = req_parity_en[i];
                sel_parity_type = req_parity_type[i];
                sel_stop2       = req_stop2[i];
            end
        end
        sel_len_bad = (sel_len < BITCNT_WIDTH'(5)) || (sel_len > BITCNT_WIDTH'(8));
    end

    assign accept    = (state_q == StIdle) && arb_en && grant_found;
    assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

    // Arbitration FSM; all sender-side and response outputs are registered here.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= StIdle;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            cnt_q         <= '0;
            en_q          <= 1'b0;
            tx_valid_q    <= 1'b0;
            resp_done_q   <= '0;
            resp_err_q    <= '0;
            timeout_q     <= 1'b0;
            tx_data_q     <= '0;
            trans_len_q   <= '0;
            parity_type_q <= 1'b0;
            parity_en_q   <= 1'b0;
            stop2_q       <= 1'b0;
        end else begin
            en_q        <= arb_en;
            tx_valid_q  <= 1'b0;
            resp_done_q <= '0;
            resp_err_q  <= '0;
            timeout_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        tx_data_q     <= sel_data;
                        trans_len_q   <= sel_len;
                        parity_en_q   <= sel_parity_en;
                        parity_type_q <= sel_parity_type;
                        stop2_q       <= sel_stop2;
                        owner_q       <= grant_idx;
                        if (sel_len_bad) begin
                            // Illegal frame length is refused without touching the sender.
                            resp_err_q <= NUM_REQ'(1) << grant_idx;
                            state_q    <= StResp;
                        end else begin
                            tx_valid_q <= 1'b1;
                            state_q    <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    cnt_q   <= '0;
                    state_q <= StBusy;
                end
                StBusy: begin
                    if (tx_err) begin
                        resp_err_q <= NUM_REQ'(1) << owner_q;
                        state_q    <= StResp;
                    end else if (tx_done) begin
                        resp_done_q <= NUM_REQ'(1) << owner_q;
                        state_q     <= StResp;
                    end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
                        resp_err_q <= NUM_REQ'(1) << owner_q;
                        timeout_q  <= 1'b1;
                        state_q    <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    rr_ptr_q <= (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx_valid    = tx_valid_q;
    assign resp_done   = resp_done_q;
    assign resp_err    = resp_err_q;
    assign timeout     = timeout_q;
    assign tx_data     = tx_data_q;
    assign trans_len   = trans_len_q;
    assign parity_type = parity_type_q;
    assign parity_en   = parity_en_q;
    assign stop2       = stop2_q;
    // Keep the sender enabled for the whole of an in-flight transfer.
    assign en          = en_q | (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with four requesters and a 16-cycle timeout.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rstn;
    logic        arb_en;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_data;
    logic [15:0] req_len;
    logic [3:0]  req_parity_en;
    logic [3:0]  req_parity_type;
    logic [3:0]  req_stop2;
    logic [3:0]  resp_done;
    logic [3:0]  resp_err;
    logic        timeout;
    logic [7:0]  tx_data;
    logic [3:0]  trans_len;
    logic        parity_type;
    logic        parity_en;
    logic        stop2;
    logic        tx_valid;
    logic        en;
    logic        tx_done;
    logic        tx_err;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .BITCNT_WIDTH (4),
        .TIMEOUT_CYC  (16)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .arb_en          (arb_en),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_data        (req_data),
        .req_len         (req_len),
        .req_parity_en   (req_parity_en),
        .req_parity_type (req_parity_type),
        .req_stop2       (req_stop2),
        .resp_done       (resp_done),
        .resp_err        (resp_err),
        .timeout         (timeout),
        .tx_data         (tx_data),
        .trans_len       (trans_len),
        .parity_type     (parity_type),
        .parity_en       (parity_en),
        .stop2           (stop2),
        .tx_valid        (tx_valid),
        .en              (en),
        .tx_done         (tx_done),
        .tx_err          (tx_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {2'b00, req_ready, resp_done, resp_err, timeout, tx_data, trans_len,
                    parity_type, parity_en, stop2, tx_valid, en}, 32'h0);
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic [3:0] l,
                           input logic pe, input logic pt, input logic s2);
        req_data[i*8 +: 8]  = d;
        req_len[i*4 +: 4]   = l;
        req_parity_en[i]    = pe;
        req_parity_type[i]  = pt;
        req_stop2[i]        = s2;
    endtask

    initial begin
        rstn            = 1'b0;
        arb_en          = 1'b0;
        req_valid       = '0;
        req_data        = '0;
        req_len         = '0;
        req_parity_en   = '0;
        req_parity_type = '0;
        req_stop2       = '0;
        tx_done         = 1'b0;
        tx_err          = 1'b0;

        // Reset state
        repeat (2) tick();
        check_all_zero("reset_outputs");
        rstn = 1'b1;
        tick();

        // Single request, tx_done stray in ISSUE must be ignored
        set_req(0, 8'hA5, 4'd8, 1'b1, 1'b1, 1'b1);
        arb_en    = 1'b1;
        req_valid = 4'b0001;
        #1;
        check("single_ready", 32'(req_ready), 32'h1);
        tick();                                    // cycle 1
        req_valid = 4'b0000;
        check("single_txvalid", 32'(tx_valid), 32'h1);
        check("single_fields", {17'h0, tx_data, trans_len, parity_type, parity_en, stop2},
              {17'h0, 8'hA5, 4'd8, 1'b1, 1'b1, 1'b1});
        check("single_en", 32'(en), 32'h1);
        tx_done = 1'b1;
        tick();                                    // cycle 2
        tx_done = 1'b0;
        check("single_txvalid_once", 32'(tx_valid), 32'h0);
        tick();                                    // cycle 3
        check("issue_done_ignored", 32'({resp_done, resp_err}), 32'h0);
        repeat (7) tick();                         // cycle 10
        tx_done = 1'b1;
        tick();                                    // cycle 11
        tx_done = 1'b0;
        check("single_resp", 32'({resp_done, resp_err, 3'b000, timeout}), 32'h100);
        tick();                                    // cycle 12
        check("single_resp_pulse", 32'(resp_done), 32'h0);
        check("single_hold_data", 32'(tx_data), 32'hA5);

        // Round robin from a fresh pointer, everyone valid continuously
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) set_req(i, 8'h10 + 8'(8'h11 * i), 4'd8, 1'b0, 1'b0, 1'b0);
        req_valid = 4'hF;
        for (int n = 0; n < 5; n++) begin
            #1;
            check("rr_ready", 32'(req_ready), 32'(4'b0001 << (n % 4)));
            tick();
            check("rr_data", 32'(tx_data), 32'(8'h10 + 8'(8'h11 * (n % 4))));
            check("rr_txvalid", 32'(tx_valid), 32'h1);
            repeat (5) tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            check("rr_done", 32'(resp_done), 32'(4'b0001 << (n % 4)));
            check("rr_ready_busy", 32'(req_ready), 32'h0);
            tick();
        end
        req_valid = 4'h0;

        // Error wins over simultaneous done (pointer now at 1)
        set_req(1, 8'h5C, 4'd7, 1'b0, 1'b0, 1'b0);
        req_valid = 4'b0010;
        #1;
        check("prio_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0000;
        check("prio_data", 32'(tx_data), 32'h5C);
        tick();
        tx_done = 1'b1;
        tx_err  = 1'b1;
        tick();
        tx_done = 1'b0;
        tx_err  = 1'b0;
        check("prio_resp", 32'({resp_done, resp_err, 3'b000, timeout}), 32'h020);
        tick();

        // Timeout with TIMEOUT_CYC = 16, length 5 is legal
        set_req(2, 8'h3C, 4'd5, 1'b0, 1'b0, 1'b0);
        req_valid = 4'b0100;
        #1;
        check("to_ready", 32'(req_ready), 32'h4);
        tick();                                    // cycle 1
        req_valid = 4'b0000;
        check("to_len5_issued", 32'({tx_valid, trans_len}), 32'h15);
        repeat (16) tick();                        // cycle 17
        check("to_not_yet", 32'({resp_err, timeout}), 32'h0);
        set_req(3, 8'h99, 4'd8, 1'b0, 1'b0, 1'b0);
        req_valid = 4'b1000;
        tick();                                    // cycle 18
        check("to_resp", 32'({resp_done, resp_err, 3'b000, timeout}), 32'h041);
        check("to_no_grant_resp", 32'(req_ready), 32'h0);
        tick();                                    // cycle 19
        check("to_next_grant", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0000;
        check("to_next_data", 32'(tx_data), 32'h99);
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("to_next_done", 32'(resp_done), 32'h8);
        tick();

        // Bad length on requester 2
        set_req(2, 8'h11, 4'd3, 1'b0, 1'b0, 1'b0);
        req_valid = 4'b0100;
        #1;
        check("badlen_ready", 32'(req_ready), 32'h4);
        tick();                                    // cycle 1
        req_valid = 4'b0000;
        check("badlen_resp", 32'({resp_done, resp_err, 3'b000, tx_valid}), 32'h040);
        check("badlen_len", 32'(trans_len), 32'h3);
        tick();                                    // cycle 2
        check("badlen_after", 32'({resp_err, tx_valid}), 32'h0);
        tick();
        check("badlen_no_txvalid", 32'(tx_valid), 32'h0);

        // arb_en dropped mid-transfer (pointer at 3, wraps to 0)
        set_req(0, 8'h77, 4'd6, 1'b0, 1'b0, 1'b0);
        req_valid = 4'b0001;
        #1;
        check("drop_ready_wrap", 32'(req_ready), 32'h1);
        tick();                                    // cycle 1
        req_valid = 4'b0000;
        tick();                                    // cycle 2
        arb_en = 1'b0;
        set_req(1, 8'hE1, 4'd7, 1'b1, 1'b1, 1'b1);
        req_valid = 4'b0010;
        tick();
        tick();                                    // cycle 4
        tx_done = 1'b1;
        tick();                                    // cycle 5
        tx_done = 1'b0;
        check("drop_done", 32'({resp_done, resp_err}), 32'h10);
        check("drop_en_busy", 32'(en), 32'h1);
        tick();
        check("drop_no_grant", 32'({req_ready, en}), 32'h0);
        tick();
        check("drop_idle", 32'({req_ready, tx_valid}), 32'h0);

        // Re-enable, then reset in the middle of BUSY
        arb_en = 1'b1;
        #1;
        check("rst_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0000;
        check("rst_issue", 32'({tx_valid, stop2, parity_en, parity_type}), 32'hF);
        tick();                                    // BUSY
        #2;
        rstn   = 1'b0;
        #1;
        check_all_zero("rst_midbusy");
        arb_en  = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        rstn    = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            check("rst_no_resp", 32'({resp_done, resp_err, timeout, tx_valid}), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares a single UART sender between NUM_REQ independent requesters. Each requester presents one byte plus its own frame configuration; the arbiter grants in round-robin order, latches the winner's data and configuration onto the sender's configuration/data inputs, issues a one-cycle tx_valid, waits for tx_done or tx_err (bounded by a timeout), and returns a per-requester completion or error pulse. It sits between the transmit clients and the sender side of uart_if.

## Interface

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- BITCNT_WIDTH, from uart_config_pkg, width of trans_len
- TIMEOUT_CYC, 65535, maximum BUSY cycles before forced error (≥2)

Ports:
- clk  in  1  single system clock
- rstn  in  1  asynchronous active-low reset
- arb_en  in  1  enables new grants
- req_valid  in  NUM_REQ  per-requester transfer request
- req_ready  out  NUM_REQ  acceptance strobe, one-hot or zero, combinational
- req_data  in  NUM_REQ*8  byte per requester, requester i at [8i+7:8i]
- req_len  in  NUM_REQ*BITCNT_WIDTH  data bits per frame, legal 5..8
- req_parity_en  in  NUM_REQ  parity enable per requester
- req_parity_type  in  NUM_REQ  0 even, 1 odd
- req_stop2  in  NUM_REQ  two stop bits
- resp_done  out  NUM_REQ  one-cycle success pulse to owner
- resp_err  out  NUM_REQ  one-cycle error pulse to owner
- timeout  out  1  one-cycle pulse when a transfer timed out
- tx_data  out  8  to sender
- trans_len  out  BITCNT_WIDTH  to sender
- parity_type  out  parity_type_t  to sender
- parity_en  out  1  to sender
- stop2  out  1  to sender
- tx_valid  out  1  one-cycle start strobe to sender
- en  out  1  sender enable
- tx_done  in  1  from sender
- tx_err  in  1  from sender

## Operation

- States: IDLE, ISSUE, BUSY, RESP.
- IDLE: if arb_en and any req_valid, winner = first valid index at or after rr_ptr, wrapping modulo NUM_REQ. req_ready[winner] = 1 in that cycle. On the clock edge, latch winner's data/len/parity_en/parity_type/stop2 into the sender output registers, latch owner index. If req_len is outside 5..8, latch bad_len and go to RESP; otherwise go to ISSUE.
- ISSUE: tx_valid = 1 for exactly this cycle; go to BUSY; clear timeout counter.
- BUSY: tx_done/tx_err are sampled only here. tx_err (priority over simultaneous tx_done) → RESP with error. tx_done → RESP with success. Counter reaching TIMEOUT_CYC−1 with neither → RESP with error and timeout.
- RESP: pulse resp_done[owner] or resp_err[owner] (also timeout if applicable); rr_ptr = (owner+1) mod NUM_REQ; go to IDLE.
- Sender output registers hold their values from acceptance until the next acceptance.
- en = arb_en registered OR (state ≠ IDLE). Dropping arb_en mid-transfer completes the current transfer with its normal response, then no further grants.
- Requesters hold valid and fields stable until ready. A valid that is dropped before ready is never served. A requester may re-request immediately after its response.

## Timing

- Reset: all outputs 0, parity_type = EVEN, rr_ptr = 0, state = IDLE, counter = 0.
- Acceptance at cycle 0 → tx_valid at cycle 1 → tx_done seen at cycle k ≥ 2 → resp pulse at k+1 → earliest next acceptance at k+2.
- Bad length: acceptance at cycle 0 → resp_err at cycle 1, no tx_valid.
- Timeout: BUSY entered at cycle 2; resp_err and timeout pulse at cycle 2+TIMEOUT_CYC.
- tx_done/tx_err asserted in IDLE, ISSUE or RESP are ignored.
- Reset mid-transfer: immediate return to reset values; no response pulse is produced.

## Test plan

- Single request: req 0 valid, data 0xA5, len 8, parity odd, stop2; tx_done at cycle 10 → req_ready[0] at 0, tx_valid at 1 with tx_data = 0xA5, trans_len = 8, parity_type = ODD, stop2 = 1; resp_done[0] at 11.
- Round-robin: all 4 requesters valid continuously, each tx_done 5 cycles after tx_valid → grant order 0,1,2,3,0; each grant 8 cycles apart.
- Error priority: tx_done and tx_err high together in BUSY → resp_err[owner] only, no resp_done.
- Timeout, TIMEOUT_CYC = 16: never assert tx_done → resp_err and timeout at cycle 18, next request granted at 19.
- Bad length: req 2 with len 3 → req_ready[2] at 0, resp_err[2] at 1, tx_valid never asserted.
- arb_en dropped in BUSY, then reset mid-BUSY on a second transfer → first transfer completes with resp_done and no new grant; after reset all outputs 0 and no resp pulse.
